preprocess_issuer: RTL and testbench

Sequencer on the driving side of the triangle preprocess stage in the intersection core (IC). It sweeps triangle memory and presents {v0,v1,v2} plus the ray origin to the preprocess stage, whose adders compute v1−v0, v2−v0 and orig−v0 with a fixed ADD_LAT. It tags each issue with a triangle ID through a matching delay line and captures the stage outputs into a result FIFO. The FIFO drains over a valid/ready port to the intersection math. The preprocess stage cannot stall, so issue is credit-limited.

---
 rtl/ic_pkg.sv | 24 ++
 rtl/preprocess_issuer_if.sv | 24 ++
 rtl/pp_result_fifo.sv | 80 ++++++++
 rtl/preprocess_issuer.sv | 202 ++++++++++++++++++++
 tb/tb_preprocess_issuer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ic_pkg.sv
// Shared types for the intersection core: float/vector widths, the
// preprocess result record and the issuer sequencer states.
package ic_pkg;

    localparam int FLT_W    = 32;
    localparam int VEC_W    = 3 * FLT_W;
    localparam int TRI_ID_W = 10;

    // One preprocessed triangle as handed to the intersection math.
    typedef struct packed {
        logic [TRI_ID_W-1:0] tri_id;
        logic [VEC_W-1:0]    v0v1;
        logic [VEC_W-1:0]    v0v2;
        logic [VEC_W-1:0]    tvec;
    } pp_result_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } issuer_state_t;

endpackage

// File: rtl/preprocess_issuer_if.sv
// Valid/ready result port from the preprocess issuer to the intersection math.
interface preprocess_issuer_if #(
    parameter int TRI_ADDR_W = 10
);
    import ic_pkg::*;

    logic                  out_valid;
    logic                  out_ready;
    logic [TRI_ADDR_W-1:0] out_tri_id;
    logic [VEC_W-1:0]      out_v0v1;
    logic [VEC_W-1:0]      out_v0v2;
    logic [VEC_W-1:0]      out_tvec;

    modport master (
        output out_valid, out_tri_id, out_v0v1, out_v0v2, out_tvec,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_tri_id, out_v0v1, out_v0v2, out_tvec,
        output out_ready
    );

endinterface

// File: rtl/pp_result_fifo.sv
// Synchronous result FIFO with occupancy count. Push and pop may coincide at
// any fill level, including full. Read data is forced to zero while empty so
// the output bus has a defined value without resetting the storage array.
module pp_result_fifo
    import ic_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  pp_result_t             wdata_i,
    input  logic                   pop_i,
    output pp_result_t             rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    pp_result_t       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage array; data only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Credit accounting upstream must never let a write land on a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push_i && full && !pop_i))
                else $error("pp_result_fifo: write to full FIFO");
        end
    end

endmodule

// File: rtl/preprocess_issuer.sv
// Drives the triangle preprocess stage: sweeps triangle memory under a credit
// limit, tags each issue with its triangle ID through a delay line matched to
// the adder latency, and captures the adder outputs into a result FIFO that
// drains over a valid/ready port.
module preprocess_issuer
    import ic_pkg::*;
#(
    parameter int TRI_ADDR_W = 10,
    parameter int ADD_LAT    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [TRI_ADDR_W:0]    num_tri,
    input  logic [VEC_W-1:0]       orig,
    output logic                   busy,
    output logic                   done,
    output logic                   tri_rd_en,
    output logic [TRI_ADDR_W-1:0]  tri_rd_addr,
    input  logic [3*VEC_W-1:0]     tri_rd_data,
    output logic [VEC_W-1:0]       pp_v0,
    output logic [VEC_W-1:0]       pp_v1,
    output logic [VEC_W-1:0]       pp_v2,
    output logic [VEC_W-1:0]       pp_orig,
    input  logic [VEC_W-1:0]       pp_v0v1,
    input  logic [VEC_W-1:0]       pp_v0v2,
    input  logic [VEC_W-1:0]       pp_tvec,
    preprocess_issuer_if.master    res
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    issuer_state_t         state_q;
    logic                  busy_q;
    logic                  done_q;
    logic [TRI_ADDR_W:0]   num_q;
    logic [VEC_W-1:0]      orig_q;
    logic [TRI_ADDR_W:0]   issue_idx_q;
    logic [TRI_ADDR_W:0]   issue_idx_d;
    logic [CNT_W-1:0]      in_flight_q;
    logic [CNT_W-1:0]      in_flight_d;
    logic [ADD_LAT:0]      tag_vld_q;
    logic [TRI_ADDR_W-1:0] tag_id_q [ADD_LAT+1];

    logic                  start_acc;
    logic                  issue;
    logic                  last_issue;
    logic                  drained;
    logic [SUM_W-1:0]      credit_sum;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    pp_result_t            wr_data;
    pp_result_t            rd_data;

    // Outstanding work is everything in the adders plus everything queued;
    // counting queued entries before this cycle's pop keeps the bound safe.
    assign credit_sum  = SUM_W'(in_flight_q) + SUM_W'(fifo_count);
    assign start_acc   = (state_q == S_IDLE) && start;
    assign issue       = (state_q == S_RUN) && (issue_idx_q < num_q)
                         && (credit_sum < SUM_W'(FIFO_DEPTH));
    assign issue_idx_d = issue_idx_q + (TRI_ADDR_W+1)'(1);
    assign last_issue  = issue && (issue_idx_d == num_q);
    assign fifo_push   = tag_vld_q[ADD_LAT];
    assign fifo_pop    = res.out_valid && res.out_ready;
    // Sweep is finished once nothing is in the adders and the FIFO is empty
    // or its last entry leaves this cycle.
    assign drained     = (in_flight_q == '0)
                         && ((fifo_count == '0)
                             || ((fifo_count == CNT_W'(1)) && fifo_pop));

    assign busy        = busy_q;
    assign done        = done_q;
    assign tri_rd_en   = issue;
    assign tri_rd_addr = issue_idx_q[TRI_ADDR_W-1:0];
    assign pp_v0       = tri_rd_data[VEC_W-1:0];
    assign pp_v1       = tri_rd_data[2*VEC_W-1:VEC_W];
    assign pp_v2       = tri_rd_data[3*VEC_W-1:2*VEC_W];
    assign pp_orig     = orig_q;

    // Sweep sequencer with registered busy/done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            num_q   <= '0;
            orig_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_q  <= num_tri;
                        orig_q <= orig;
                        busy_q <= 1'b1;
                        if (num_tri == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (last_issue) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Adder occupancy: up on issue, down when the tagged result is captured.
    always_comb begin
        in_flight_d = in_flight_q;
        case ({issue, fifo_push})
            2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
            2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    // Issue index and in-flight credit counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_idx_q <= '0;
            in_flight_q <= '0;
        end else begin
            if (start_acc) begin
                issue_idx_q <= '0;
            end else if (issue) begin
                issue_idx_q <= issue_idx_d;
            end
            in_flight_q <= in_flight_d;
        end
    end

    // Tag valid bits: one read-data cycle plus ADD_LAT adder cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[ADD_LAT-1:0], issue};
        end
    end

    // Tag IDs ride alongside the valid bits; qualified by them, so no reset.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= issue_idx_q[TRI_ADDR_W-1:0];
        for (int k = 1; k <= ADD_LAT; k++) begin
            tag_id_q[k] <= tag_id_q[k-1];
        end
    end

    // Pack the adder outputs with the matching tag for the FIFO.
    always_comb begin
        wr_data        = '0;
        wr_data.tri_id = TRI_ID_W'(tag_id_q[ADD_LAT]);
        wr_data.v0v1   = pp_v0v1;
        wr_data.v0v2   = pp_v0v2;
        wr_data.tvec   = pp_tvec;
    end

    pp_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (wr_data),
        .pop_i   (fifo_pop),
        .rdata_o (rd_data),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign res.out_valid  = !fifo_empty;
    assign res.out_tri_id = rd_data.tri_id[TRI_ADDR_W-1:0];
    assign res.out_v0v1   = rd_data.v0v1;
    assign res.out_v0v2   = rd_data.v0v2;
    assign res.out_tvec   = rd_data.tvec;

endmodule

// File: tb/tb_preprocess_issuer.sv
// Scoreboard bench for preprocess_issuer: behavioural triangle memory and
// float-subtract preprocess stage, expected results queued at issue and
// checked by a separate output monitor.
module tb_preprocess_issuer;
    import ic_pkg::*;

    localparam int AW = 10;
    localparam int L  = 3;
    localparam int D  = 8;

    typedef struct packed {
        logic [AW-1:0] id;
        logic [95:0]   a;
        logic [95:0]   b;
        logic [95:0]   c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   num_tri = '0;
    logic [95:0]   orig = '0;
    logic          busy, done, tri_rd_en;
    logic [AW-1:0] tri_rd_addr;
    logic [287:0]  tri_rd_data = '0;
    logic [95:0]   pp_v0, pp_v1, pp_v2, pp_orig;
    logic [95:0]   pp_v0v1, pp_v0v2, pp_tvec;
    logic [95:0]   m01 [L];
    logic [95:0]   m02 [L];
    logic [95:0]   mtv [L];

    preprocess_issuer_if #(.TRI_ADDR_W(AW)) rif ();

    preprocess_issuer #(.TRI_ADDR_W(AW), .ADD_LAT(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tri(num_tri), .orig(orig),
        .busy(busy), .done(done), .tri_rd_en(tri_rd_en), .tri_rd_addr(tri_rd_addr),
        .tri_rd_data(tri_rd_data), .pp_v0(pp_v0), .pp_v1(pp_v1), .pp_v2(pp_v2),
        .pp_orig(pp_orig), .pp_v0v1(pp_v0v1), .pp_v0v2(pp_v0v2), .pp_tvec(pp_tvec),
        .res(rif.master)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0, n_err = 0;
    int   cyc = 0;
    int   tmode = 0;
    int   n_iss, n_pop, n_done, exp_idx, max_out;
    int   first_iss, last_iss, first_val, last_pop, done_cyc;
    bit   seen_val, prev_stall;
    logic [319:0] held;
    int   id_seen [32];
    exp_t sb [$];
    exp_t e;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  ex;
        if (b[30:23] == 8'd0) return 0.0;
        m  = 1.0 + real'(b[22:0]) / 8388608.0;
        ex = int'(b[30:23]) - 127;
        while (ex > 0) begin m = m * 2.0; ex--; end
        while (ex < 0) begin m = m / 2.0; ex++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real  a;
        int   ex;
        int   m;
        logic s;
        if (v == 0.0) return 32'd0;
        s  = (v < 0.0);
        a  = s ? -v : v;
        ex = 127;
        while (a >= 2.0) begin a = a / 2.0; ex++; end
        while (a < 1.0) begin a = a * 2.0; ex--; end
        m = int'((a - 1.0) * 8388608.0);
        return {s, ex[7:0], m[22:0]};
    endfunction

    function automatic logic [95:0] vec3(input int x, input int y, input int z);
        return {r2f(real'(z)), r2f(real'(y)), r2f(real'(x))};
    endfunction

    function automatic logic [95:0] sub3(input logic [95:0] a, input logic [95:0] b);
        return {r2f(f2r(a[95:64]) - f2r(b[95:64])),
                r2f(f2r(a[63:32]) - f2r(b[63:32])),
                r2f(f2r(a[31:0])  - f2r(b[31:0]))};
    endfunction

    // Triangle memory contents, {v2,v1,v0}.
    function automatic logic [287:0] tri_word(input int i);
        if (tmode == 1) return {vec3(0, 0, 0), vec3(4, 6, 8), vec3(1, 2, 3)};
        return {vec3(0, i, 5), vec3(i + 1, 2 * i + 3, 4), vec3(i, 2 * i, 1)};
    endfunction

    // Hand-derived results; sweep tests use orig = (7,7,7).
    function automatic exp_t exp_for(input int i);
        exp_t r;
        r.id = AW'(i);
        if (tmode == 1) begin
            r.a = {32'h40A00000, 32'h40800000, 32'h40400000};
            r.b = {32'hC0400000, 32'hC0000000, 32'hBF800000};
            r.c = {32'hC0000000, 32'hBF800000, 32'h00000000};
        end else begin
            r.a = vec3(1, 3, 3);
            r.b = vec3(-i, -i, 4);
            r.c = vec3(7 - i, 7 - 2 * i, 6);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Triangle memory: data valid one cycle after the read strobe.
    always @(posedge clk) begin
        if (tri_rd_en) tri_rd_data <= tri_word(int'(tri_rd_addr));
    end

    // Preprocess stage model: three float subtractions, L cycles deep.
    always @(posedge clk) begin
        m01[0] <= sub3(pp_v1, pp_v0);
        m02[0] <= sub3(pp_v2, pp_v0);
        mtv[0] <= sub3(pp_orig, pp_v0);
        for (int k = 1; k < L; k++) begin
            m01[k] <= m01[k-1];
            m02[k] <= m02[k-1];
            mtv[k] <= mtv[k-1];
        end
    end
    assign pp_v0v1 = m01[L-1];
    assign pp_v0v2 = m02[L-1];
    assign pp_tvec = mtv[L-1];

    // Issue and output monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (tri_rd_en) begin
                    if (n_iss == 0) first_iss = cyc;
                    last_iss = cyc;
                    chk("issue_addr", 320'(tri_rd_addr), 320'(exp_idx));
                    sb.push_back(exp_for(exp_idx));
                    exp_idx++;
                    n_iss++;
                end
                if (prev_stall) begin
                    chk("hold_valid", 320'(rif.out_valid), 320'(1));
                    chk("hold_data", {22'd0, rif.out_tri_id, rif.out_v0v1, rif.out_v0v2,
                                      rif.out_tvec}, held);
                end
                if (rif.out_valid && !seen_val) begin
                    first_val = cyc;
                    seen_val  = 1'b1;
                end
                if (rif.out_valid && rif.out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_output: id %0d with empty scoreboard",
                                 rif.out_tri_id);
                    end else begin
                        e = sb.pop_front();
                        chk("out_tri_id", 320'(rif.out_tri_id), 320'(e.id));
                        chk("out_v0v1", 320'(rif.out_v0v1), 320'(e.a));
                        chk("out_v0v2", 320'(rif.out_v0v2), 320'(e.b));
                        chk("out_tvec", 320'(rif.out_tvec), 320'(e.c));
                    end
                    if (rif.out_tri_id < AW'(32)) id_seen[int'(rif.out_tri_id)]++;
                    n_pop++;
                    last_pop = cyc;
                end
                if (done) begin
                    done_cyc = cyc;
                    n_done++;
                end
                if (n_iss - n_pop > max_out) max_out = n_iss - n_pop;
                prev_stall = rif.out_valid && !rif.out_ready;
                held = {22'd0, rif.out_tri_id, rif.out_v0v1, rif.out_v0v2, rif.out_tvec};
            end
        end
    end

    task automatic clear_stats();
        n_iss = 0; n_pop = 0; n_done = 0; exp_idx = 0; max_out = 0;
        first_iss = 0; last_iss = 0; first_val = 0; last_pop = 0; done_cyc = 0;
        seen_val = 1'b0;
        for (int i = 0; i < 32; i++) id_seen[i] = 0;
    endtask

    task automatic run_start(input int n, input logic [95:0] o);
        @(posedge clk); #1;
        start = 1'b1; num_tri = (AW+1)'(n); orig = o;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string nm);
        int k;
        k = 0;
        while (n_done == 0 && k < maxc) begin @(posedge clk); k++; end
        n_cmp++;
        if (n_done == 0) begin
            n_err++;
            $display("FAIL %s: done not seen within %0d cycles", nm, maxc);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rif.out_ready = 1'b0;
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 320'(busy), 320'(0));
        chk("rst_done", 320'(done), 320'(0));
        chk("rst_rd_en", 320'(tri_rd_en), 320'(0));
        chk("rst_rd_addr", 320'(tri_rd_addr), 320'(0));
        chk("rst_out_valid", 320'(rif.out_valid), 320'(0));
        chk("rst_out_tri_id", 320'(rif.out_tri_id), 320'(0));
        chk("rst_out_v0v1", 320'(rif.out_v0v1), 320'(0));
        chk("rst_out_v0v2", 320'(rif.out_v0v2), 320'(0));
        chk("rst_out_tvec", 320'(rif.out_tvec), 320'(0));
        chk("rst_pp_orig", 320'(pp_orig), 320'(0));
        @(posedge clk); #1 rst = 1'b1;

        // Single triangle with hand-computed float results.
        tmode = 1;
        clear_stats();
        rif.out_ready = 1'b1;
        run_start(1, vec3(1, 1, 1));
        wait_done(100, "t1_done");
        chk("t1_issues", 320'(n_iss), 320'(1));
        chk("t1_pops", 320'(n_pop), 320'(1));
        chk("t1_latency", 320'(first_val - first_iss), 320'(L + 2));
        chk("t1_done_after_pop", 320'(done_cyc - last_pop), 320'(1));
        chk("t1_pp_orig", 320'(pp_orig), 320'(vec3(1, 1, 1)));
        chk("t1_sb_empty", 320'(sb.size()), 320'(0));

        // Empty sweep.
        tmode = 0;
        clear_stats();
        run_start(0, vec3(7, 7, 7));
        @(negedge clk);
        chk("t2_busy_hi", 320'(busy), 320'(1));
        chk("t2_done_hi", 320'(done), 320'(1));
        @(negedge clk);
        chk("t2_busy_lo", 320'(busy), 320'(0));
        chk("t2_done_lo", 320'(done), 320'(0));
        chk("t2_no_reads", 320'(n_iss), 320'(0));

        // Full-rate sweep.
        clear_stats();
        run_start(20, vec3(7, 7, 7));
        wait_done(300, "t3_done");
        chk("t3_issues", 320'(n_iss), 320'(20));
        chk("t3_back_to_back", 320'(last_iss - first_iss), 320'(19));
        chk("t3_pops", 320'(n_pop), 320'(20));
        chk("t3_sb_empty", 320'(sb.size()), 320'(0));

        // Consumer stalled: issue must stop at the credit limit.
        clear_stats();
        rif.out_ready = 1'b0;
        run_start(20, vec3(7, 7, 7));
        repeat (30) @(posedge clk);
        #1;
        chk("t4_stalled_issues", 320'(n_iss), 320'(D));
        chk("t4_max_outstanding", 320'(max_out), 320'(D));
        rif.out_ready = 1'b1;
        wait_done(400, "t4_done");
        chk("t4_pops", 320'(n_pop), 320'(20));
        chk("t4_sb_empty", 320'(sb.size()), 320'(0));

        // Random backpressure.
        clear_stats();
        run_start(20, vec3(7, 7, 7));
        k = 0;
        while (n_done == 0 && k < 600) begin
            @(posedge clk); #1;
            rif.out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        n_cmp++;
        if (n_done == 0) begin
            n_err++;
            $display("FAIL t5_done: done not seen within 600 cycles");
        end
        rif.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t5_pops", 320'(n_pop), 320'(20));
        for (int i = 0; i < 20; i++) chk("t5_id_once", 320'(id_seen[i]), 320'(1));
        chk("t5_sb_empty", 320'(sb.size()), 320'(0));

        // Reset in the middle of a stalled sweep, then a fresh short sweep.
        clear_stats();
        rif.out_ready = 1'b0;
        run_start(20, vec3(7, 7, 7));
        repeat (L + 6) @(posedge clk);
        #1;
        chk("t6_fifo_nonempty", 320'(rif.out_valid), 320'(1));
        rst = 1'b0;
        sb.delete();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_valid_cleared", 320'(rif.out_valid), 320'(0));
        chk("t6_busy_cleared", 320'(busy), 320'(0));
        clear_stats();
        rif.out_ready = 1'b1;
        run_start(2, vec3(7, 7, 7));
        wait_done(100, "t6_done");
        chk("t6_issues", 320'(n_iss), 320'(2));
        chk("t6_pops", 320'(n_pop), 320'(2));
        chk("t6_id0", 320'(id_seen[0]), 320'(1));
        chk("t6_id1", 320'(id_seen[1]), 320'(1));
        chk("t6_sb_empty", 320'(sb.size()), 320'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
